// File: rtl/instr_field_queue.sv
// ---------------------------------------------------------------------------
// instr_field_queue
//
// Instruction queue sitting between fetch and decode. It holds up to DEPTH
// {instruction, PC} pairs in a circular buffer and presents the MIPS fields
// of the head entry combinationally to the controller / GRF address logic.
// An empty queue presents an all-zero word (sll $0,$0,0, i.e. a NOP).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high (push = in_valid & in_ready, pop = out_valid & out_ready).
// in_ready depends only on occupancy, so a full queue refuses a push even
// if a pop happens in the same cycle. No same-cycle fall-through.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   flush               synchronous discard of all entries (redirect)
//   in_valid/in_ready   fetch-side handshake, in_instr/in_pc payload
//   out_valid/out_ready decode-side handshake, out_instr/out_pc head entry
//   special..imm26      MIPS field slices of the head instruction
//   imm_sext/imm_zext   imm16 sign-/zero-extended to 32 bits
//   count               number of stored entries
// ---------------------------------------------------------------------------
module instr_field_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [5:0]                 special,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [4:0]                 shamt,
    output logic [5:0]                 funct,
    output logic [15:0]                imm16,
    output logic [25:0]                imm26,
    output logic [31:0]                imm_sext,
    output logic [31:0]                imm_zext,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [31:0]     r_mem_instr [DEPTH];
    logic [PC_W-1:0] r_mem_pc    [DEPTH];
    logic [AW-1:0]   r_wp;
    logic [AW-1:0]   r_rp;
    logic [CW-1:0]   r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_clear;
    logic            w_nonempty;
    logic [31:0]     w_head_instr;
    logic [PC_W-1:0] w_head_pc;

    assign w_nonempty = (r_count != '0);
    assign in_ready   = (r_count != FULL_COUNT);
    assign out_valid  = w_nonempty;
    assign w_clear    = reset | flush;
    assign w_push     = in_valid & in_ready;
    assign w_pop      = w_nonempty & out_ready;

    // Storage has no reset; entries are only observable while counted.
    always_ff @(posedge clk) begin
        if (!w_clear && w_push) begin
            r_mem_instr[r_wp] <= in_instr;
            r_mem_pc[r_wp]    <= in_pc;
        end
    end

    // reset and flush share one path; either discards any same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + AW'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Empty queue presents zeros so decode sees a NOP.
    assign w_head_instr = w_nonempty ? r_mem_instr[r_rp] : '0;
    assign w_head_pc    = w_nonempty ? r_mem_pc[r_rp]    : '0;

    assign out_instr = w_head_instr;
    assign out_pc    = w_head_pc;
    assign special   = w_head_instr[31:26];
    assign rs        = w_head_instr[25:21];
    assign rt        = w_head_instr[20:16];
    assign rd        = w_head_instr[15:11];
    assign shamt     = w_head_instr[10:6];
    assign funct     = w_head_instr[5:0];
    assign imm16     = w_head_instr[15:0];
    assign imm26     = w_head_instr[25:0];
    assign imm_sext  = {{16{w_head_instr[15]}}, w_head_instr[15:0]};
    assign imm_zext  = {16'h0000, w_head_instr[15:0]};
    assign count     = r_count;

endmodule

// File: tb/tb_instr_field_queue.sv
module tb_instr_field_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FW    = 6 + 5 + 5 + 5 + 5 + 6 + 16 + 26 + 32 + 32;
    localparam int VW    = 1 + 1 + CW + 32 + PC_W + FW;

    logic            clk;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     out_instr;
    logic [PC_W-1:0] out_pc;
    logic [5:0]      special;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [15:0]     imm16;
    logic [25:0]     imm26;
    logic [31:0]     imm_sext;
    logic [31:0]     imm_zext;
    logic [CW-1:0]   count;

    int n_checks;
    int n_errors;

    // Reference model: a plain queue of {instr, pc}.
    logic [31+PC_W:0] mq[$];
    logic [31+PC_W:0] last_pop;

    logic [VW-1:0] act_vec;
    assign act_vec = {out_valid, in_ready, count, out_instr, out_pc,
                      special, rs, rt, rd, shamt, funct, imm16, imm26,
                      imm_sext, imm_zext};

    instr_field_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .special(special), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt),
        .funct(funct), .imm16(imm16), .imm26(imm26),
        .imm_sext(imm_sext), .imm_zext(imm_zext), .count(count)
    );

    // ------------------------------------------------------------ clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected full output vector derived from the model's head entry.
    function automatic logic [VW-1:0] exp_vec();
        logic [31:0]     e;
        logic [PC_W-1:0] p;
        e = '0;
        p = '0;
        if (mq.size() != 0) begin
            e = mq[0][31+PC_W:PC_W];
            p = mq[0][PC_W-1:0];
        end
        return {mq.size() != 0, mq.size() != DEPTH, CW'(mq.size()), e, p,
                e[31:26], e[25:21], e[20:16], e[15:11], e[10:6], e[5:0],
                e[15:0], e[25:0], {{16{e[15]}}, e[15:0]}, {16'h0000, e[15:0]}};
    endfunction

    // ------------------------------------------------------------ driver
    // Drives one cycle of inputs, waits for the edge, then updates the model.
    task automatic drive(input logic iv, input logic [31:0] ii,
                         input logic [PC_W-1:0] ip, input logic orr,
                         input logic fl, input logic rst_i,
                         output logic pushed, output logic popped);
        bit full_before;
        bit empty_before;
        in_valid  = iv;
        in_instr  = ii;
        in_pc     = ip;
        out_ready = orr;
        flush     = fl;
        reset     = rst_i;
        full_before  = (mq.size() == DEPTH);
        empty_before = (mq.size() == 0);
        @(posedge clk);
        #1;
        pushed = 1'b0;
        popped = 1'b0;
        if (rst_i || fl) begin
            mq.delete();
        end else begin
            popped = !empty_before && orr;
            pushed = iv && !full_before;
            if (popped) last_pop = mq.pop_front();
            if (pushed) mq.push_back({ii, ip});
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic idle();
        logic pu, po;
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b0, pu, po);
    endtask

    // ------------------------------------------------------------ tests
    task automatic test_reset();
        logic pu, po;
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1, pu, po);
        drive(1'b0, 32'h0, '0, 1'b0, 1'b0, 1'b1, pu, po);
        n_checks++;
        if (act_vec !== {1'b0, 1'b1, {(VW-2){1'b0}}}) begin
            n_errors++;
            $display("FAIL reset_values: got %h expected out_valid=0 in_ready=1 rest 0", act_vec);
        end
    endtask

    task automatic test_fields();
        logic pu, po;
        drive(1'b1, 32'h012A4020, 32'h1000, 1'b0, 1'b0, 1'b0, pu, po);
        n_checks++;
        if ({out_valid, special, rs, rt, rd, shamt, funct, count} !==
            {1'b1, 6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 3'd1}) begin
            n_errors++;
            $display("FAIL add_fields: got v=%b sp=%h rs=%0d rt=%0d rd=%0d sh=%0d fn=%h cnt=%0d expected 1 0 9 10 8 0 20 1",
                     out_valid, special, rs, rt, rd, shamt, funct, count);
        end
        drive(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0, pu, po);
        n_checks++;
        if (out_valid !== 1'b0 || out_instr !== 32'h0) begin
            n_errors++;
            $display("FAIL empty_after_pop: got v=%b instr=%h expected 0 0", out_valid, out_instr);
        end
    endtask

    task automatic test_extend();
        logic pu, po;
        drive(1'b1, 32'h2108FFFF, 32'h2000, 1'b0, 1'b0, 1'b0, pu, po);
        drive(1'b1, 32'h08000C00, 32'h2004, 1'b0, 1'b0, 1'b0, pu, po);
        n_checks++;
        if ({imm16, imm_sext, imm_zext} !== {16'hFFFF, 32'hFFFFFFFF, 32'h0000FFFF}) begin
            n_errors++;
            $display("FAIL imm_extend: got imm16=%h sext=%h zext=%h expected ffff ffffffff 0000ffff",
                     imm16, imm_sext, imm_zext);
        end
        drive(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0, pu, po);
        n_checks++;
        if ({special, imm26, out_pc} !== {6'h02, 26'h0000C00, 32'h2004}) begin
            n_errors++;
            $display("FAIL jump_fields: got sp=%h imm26=%h pc=%h expected 02 0000c00 2004",
                     special, imm26, out_pc);
        end
        drive(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0, pu, po);
    endtask

    task automatic test_full();
        logic pu, po;
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, $urandom, 32'h3000 + 32'(4 * k), 1'b0, 1'b0, 1'b0, pu, po);
            if (k == 3) begin
                n_checks++;
                if (count !== 3'd4 || in_ready !== 1'b0) begin
                    n_errors++;
                    $display("FAIL full_after_4: got cnt=%0d in_ready=%b expected 4 0", count, in_ready);
                end
            end
        end
        n_checks++;
        if (count !== 3'd4 || out_pc !== 32'h3000 || act_vec !== exp_vec()) begin
            n_errors++;
            $display("FAIL full_refuse: got cnt=%0d pc=%h expected 4 3000", count, out_pc);
        end
        // Pop and push together while full: push refused, count drops.
        drive(1'b1, 32'h0, 32'h5000, 1'b1, 1'b0, 1'b0, pu, po);
        n_checks++;
        if (count !== 3'd3 || in_ready !== 1'b1 || out_pc !== 32'h3004) begin
            n_errors++;
            $display("FAIL full_pop_push: got cnt=%0d in_ready=%b pc=%h expected 3 1 3004",
                     count, in_ready, out_pc);
        end
        drive(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0, pu, po);
    endtask

    task automatic test_back_to_back();
        logic pu, po;
        int pushed_n;
        int popped_n;
        int cyc;
        pushed_n = 0;
        popped_n = 0;
        cyc = 0;
        while (popped_n < 10 && cyc < 300) begin
            drive(pushed_n < 10, $urandom, 32'h3000 + 32'(4 * pushed_n),
                  ($urandom_range(0, 3) != 0), 1'b0, 1'b0, pu, po);
            cyc++;
            if (pu) pushed_n++;
            if (po) begin
                n_checks++;
                if (last_pop[PC_W-1:0] !== 32'h3000 + 32'(4 * popped_n)) begin
                    n_errors++;
                    $display("FAIL wrap_order: model popped pc=%h expected %h",
                             last_pop[PC_W-1:0], 32'h3000 + 32'(4 * popped_n));
                end
                popped_n++;
            end
            n_checks++;
            if (act_vec !== exp_vec() || count > 3'd4) begin
                n_errors++;
                $display("FAIL wrap_outputs: got %h expected %h", act_vec, exp_vec());
            end
        end
        n_checks++;
        if (popped_n != 10) begin
            n_errors++;
            $display("FAIL wrap_timeout: got %0d pops expected 10", popped_n);
        end
    endtask

    task automatic test_flush();
        logic pu, po;
        for (int k = 0; k < 3; k++) drive(1'b1, $urandom, 32'h4000 + 32'(4 * k), 1'b0, 1'b0, 1'b0, pu, po);
        drive(1'b1, 32'hDEADBEEF, 32'h400C, 1'b1, 1'b1, 1'b0, pu, po);
        n_checks++;
        if (act_vec !== {1'b0, 1'b1, {(VW-2){1'b0}}}) begin
            n_errors++;
            $display("FAIL flush_clear: got %h expected out_valid=0 in_ready=1 rest 0", act_vec);
        end
        drive(1'b1, 32'h00851820, 32'h5000, 1'b0, 1'b0, 1'b0, pu, po);
        n_checks++;
        if (count !== 3'd1 || out_instr !== 32'h00851820 || out_pc !== 32'h5000) begin
            n_errors++;
            $display("FAIL flush_then_push: got cnt=%0d instr=%h pc=%h expected 1 00851820 5000",
                     count, out_instr, out_pc);
        end
        drive(1'b0, 32'h0, '0, 1'b0, 1'b1, 1'b0, pu, po);
    endtask

    task automatic test_reset_mid();
        logic pu, po;
        drive(1'b1, 32'hFFFFFFFF, 32'h6000, 1'b0, 1'b0, 1'b0, pu, po);
        drive(1'b1, 32'hFFFFFFFF, 32'h6004, 1'b0, 1'b0, 1'b0, pu, po);
        drive(1'b1, 32'h12345678, 32'h6008, 1'b1, 1'b1, 1'b1, pu, po);
        n_checks++;
        if (act_vec !== {1'b0, 1'b1, {(VW-2){1'b0}}}) begin
            n_errors++;
            $display("FAIL reset_mid: got %h expected reset values", act_vec);
        end
        drive(1'b1, 32'h00000000, 32'h0, 1'b0, 1'b0, 1'b0, pu, po);
        n_checks++;
        if (out_valid !== 1'b1 || count !== 3'd1 || act_vec[FW-1:0] !== '0) begin
            n_errors++;
            $display("FAIL nop_push: got v=%b cnt=%0d fields=%h expected 1 1 0",
                     out_valid, count, act_vec[FW-1:0]);
        end
        drive(1'b0, 32'h0, '0, 1'b1, 1'b0, 1'b0, pu, po);
    endtask

    task automatic test_random();
        logic pu, po;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 2) != 0, $urandom, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 30) == 0,
                  $urandom_range(0, 60) == 0, pu, po);
            n_checks++;
            if (act_vec !== exp_vec()) begin
                n_errors++;
                $display("FAIL random_outputs cycle %0d: got %h expected %h", c, act_vec, exp_vec());
            end
        end
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        test_reset();
        test_fields();
        test_extend();
        test_full();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
